// File: rtl/shiftreg_pkg.sv
// Shared definitions for the serial shift-register transmitter and its
// matching receiver: FSM state type and the default word width.
package shiftreg_pkg;

    localparam int SHIFTREG_DATA_W_DEFAULT = 24;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } shiftreg_state_e;

endpackage

// File: rtl/shiftreg_tx.sv
// Parallel-to-serial transmitter with a one-word holding register.
// A word is accepted into the holding register on a valid/ready handshake,
// moved into the shift register when the shifter is free, and sent one bit
// per cycle in which shift_en is high. Consecutive words are sent without
// an idle gap when the next word is already held.
//
// Ports:
//   clk          system clock, rising edge
//   reset_ni     synchronous active-low reset
//   din_parallel word to serialize
//   din_valid    din_parallel valid
//   din_ready    holding register empty (handshake when valid && ready)
//   shift_en     bit-rate enable, one bit advances per enabled cycle
//   dout_serial  serial data, IDLE_LEVEL outside a frame
//   frame_o      high while a word is being shifted out
//   trigger_o    one-cycle pulse on the first cycle of each word
//   done_o       one-cycle pulse when the last frame ends with no word held
module shiftreg_tx
    import shiftreg_pkg::*;
#(
    parameter int   DATA_WIDTH = SHIFTREG_DATA_W_DEFAULT,
    parameter int   MSB_FIRST  = 1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset_ni,
    input  logic [DATA_WIDTH-1:0] din_parallel,
    input  logic                  din_valid,
    output logic                  din_ready,
    input  logic                  shift_en,
    output logic                  dout_serial,
    output logic                  frame_o,
    output logic                  trigger_o,
    output logic                  done_o
);

    localparam int               CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    shiftreg_state_e       r_state;
    shiftreg_state_e       w_state_nxt;
    logic [DATA_WIDTH-1:0] r_hold;
    logic                  r_hold_valid;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] w_shift_adv;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic                  r_trigger;
    logic                  r_done;
    logic                  w_accept;
    logic                  w_last;
    logic                  w_load;
    logic                  w_advance;
    logic                  w_done_nxt;
    logic                  w_out_bit;
    logic                  w_dout;
    logic                  w_frame;

    // Ready depends on registered state only, so there is no
    // combinational path from din_valid back to din_ready.
    assign w_accept = din_valid && !r_hold_valid;
    assign w_last   = (r_bit_cnt == LAST_BIT);

    // Shift toward whichever end drives the serial output.
    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_out_bit   = r_shift[DATA_WIDTH-1];
            assign w_shift_adv = {r_shift[DATA_WIDTH-2:0], 1'b0};
        end else begin : g_lsb_first
            assign w_out_bit   = r_shift[0];
            assign w_shift_adv = {1'b0, r_shift[DATA_WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_advance   = 1'b0;
        w_done_nxt  = 1'b0;
        w_dout      = IDLE_LEVEL;
        w_frame     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Loading from the holding register does not wait for shift_en.
                if (r_hold_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                w_dout  = w_out_bit;
                w_frame = 1'b1;
                if (shift_en) begin
                    if (!w_last) begin
                        w_advance = 1'b1;
                    end else if (r_hold_valid) begin
                        // Back-to-back reload keeps the frame continuous.
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_ni) begin
            r_state      <= ST_IDLE;
            r_hold_valid <= 1'b0;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_trigger    <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_trigger <= w_load;
            r_done    <= w_done_nxt;
            if (w_load) begin
                r_shift   <= r_hold;
                r_bit_cnt <= '0;
            end else if (w_advance) begin
                r_shift   <= w_shift_adv;
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end
            // Accept and load are exclusive: accept needs an empty holder,
            // load needs a full one.
            if (w_load) begin
                r_hold_valid <= 1'b0;
            end else if (w_accept) begin
                r_hold_valid <= 1'b1;
            end
        end
    end

    // Held data needs no reset; r_hold_valid qualifies it.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_hold <= din_parallel;
        end
    end

    assign din_ready   = !r_hold_valid;
    assign dout_serial = w_dout;
    assign frame_o     = w_frame;
    assign trigger_o   = r_trigger;
    assign done_o      = r_done;

endmodule

// File: tb/tb_shiftreg_tx.sv
module tb_shiftreg_tx;

    logic       clk;
    logic       reset_ni;
    logic [7:0] din_parallel;
    logic       din_valid;
    logic       shift_en;

    logic rdy_m, dout_m, frame_m, trig_m, done_m;
    logic rdy_l, dout_l, frame_l, trig_l, done_l;

    int checks = 0;
    int errors = 0;

    logic [7:0] pend[$];
    logic [7:0] sb_m[$];
    logic [7:0] sb_l[$];
    logic [7:0] rx_m;
    logic [7:0] rx_l;
    int         rx_cnt   = 0;
    int         rx_words = 0;

    typedef struct {
        string      name;
        logic [7:0] word;
        logic [3:0] en;
        logic [7:0] exp_m;
        logic [7:0] exp_l;
    } vec_t;

    vec_t vecs[5];

    shiftreg_tx #(.DATA_WIDTH(8), .MSB_FIRST(1), .IDLE_LEVEL(1'b0)) u_dut_m (
        .clk(clk), .reset_ni(reset_ni), .din_parallel(din_parallel),
        .din_valid(din_valid), .din_ready(rdy_m), .shift_en(shift_en),
        .dout_serial(dout_m), .frame_o(frame_m), .trigger_o(trig_m), .done_o(done_m)
    );

    shiftreg_tx #(.DATA_WIDTH(8), .MSB_FIRST(0), .IDLE_LEVEL(1'b1)) u_dut_l (
        .clk(clk), .reset_ni(reset_ni), .din_parallel(din_parallel),
        .din_valid(din_valid), .din_ready(rdy_l), .shift_en(shift_en),
        .dout_serial(dout_l), .frame_o(frame_l), .trigger_o(trig_l), .done_o(done_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk2(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkint(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Handshake capture and serial receiver, sampled mid-cycle.
    task automatic sample();
        logic [7:0] e;
        if (!reset_ni) begin
            rx_cnt = 0;
        end else begin
            if (din_valid && rdy_m) begin
                sb_m.push_back(din_parallel);
                sb_l.push_back(din_parallel);
                void'(pend.pop_front());
            end
            if (frame_m && shift_en) rx_m = {rx_m[6:0], dout_m};
            if (frame_l && shift_en) rx_l = {dout_l, rx_l[7:1]};
            if (frame_m && shift_en) begin
                rx_cnt++;
                if (rx_cnt == 8) begin
                    rx_cnt = 0;
                    rx_words++;
                    if (sb_m.size() == 0 || sb_l.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_pop: word %h received with none expected", rx_m);
                    end else begin
                        e = sb_m.pop_front();
                        chkint("rx_word_msb", int'(rx_m), int'(e));
                        e = sb_l.pop_front();
                        chkint("rx_word_lsb", int'(rx_l), int'(e));
                    end
                end
            end
        end
    endtask

    task automatic drive();
        din_valid = (pend.size() != 0);
        din_parallel = din_valid ? pend[0] : 8'($urandom);
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic run_vec(input vec_t v);
        int  k;
        int  phase;
        int  guard;
        logic first;
        pend.push_back(v.word);
        drive();
        shift_en = 1'b1;
        tick();
        chk2({v.name, "_ready_held"}, {rdy_m, rdy_l}, 2'b00);
        chk2({v.name, "_idle_frame"}, {frame_m, frame_l}, 2'b00);
        chk2({v.name, "_idle_dout"}, {dout_m, dout_l}, 2'b01);
        chk2({v.name, "_idle_trig"}, {trig_m, trig_l}, 2'b00);
        tick();
        k = 0; phase = 0; guard = 0; first = 1'b1;
        while (k < 8 && guard < 64) begin
            shift_en = v.en[phase];
            phase = (phase + 1) % 4;
            chk2({v.name, "_dout"}, {dout_m, dout_l}, {v.exp_m[3'(7 - k)], v.exp_l[3'(7 - k)]});
            chk2({v.name, "_frame"}, {frame_m, frame_l}, 2'b11);
            chk2({v.name, "_trig"}, {trig_m, trig_l}, {first, first});
            chk2({v.name, "_done_early"}, {done_m, done_l}, 2'b00);
            first = 1'b0;
            guard++;
            tick();
            if (shift_en) k++;
        end
        chkint({v.name, "_bits"}, k, 8);
        chk2({v.name, "_done"}, {done_m, done_l}, 2'b11);
        chk2({v.name, "_end_frame"}, {frame_m, frame_l}, 2'b00);
        chk2({v.name, "_end_dout"}, {dout_m, dout_l}, 2'b01);
        chk2({v.name, "_end_ready"}, {rdy_m, rdy_l}, 2'b11);
        shift_en = 1'b0;
        tick();
        chk2({v.name, "_done_once"}, {done_m, done_l}, 2'b00);
    endtask

    initial begin
        logic [15:0] exp16_m;
        logic [15:0] exp16_l;
        logic        t;
        logic        r;
        int          guard;
        int          base;

        vecs[0] = '{name: "A5", word: 8'hA5, en: 4'b1111, exp_m: 8'b10100101, exp_l: 8'b10100101};
        vecs[1] = '{name: "01", word: 8'h01, en: 4'b1111, exp_m: 8'b00000001, exp_l: 8'b10000000};
        vecs[2] = '{name: "C3", word: 8'hC3, en: 4'b1001, exp_m: 8'b11000011, exp_l: 8'b11000011};
        vecs[3] = '{name: "36", word: 8'h36, en: 4'b0101, exp_m: 8'b00110110, exp_l: 8'b01101100};
        vecs[4] = '{name: "80", word: 8'h80, en: 4'b0011, exp_m: 8'b10000000, exp_l: 8'b00000001};

        reset_ni = 1'b0;
        din_valid = 1'b0;
        din_parallel = 8'h00;
        shift_en = 1'b0;
        rx_m = 8'h00;
        rx_l = 8'h00;
        repeat (3) tick();
        chk2("rst_ready", {rdy_m, rdy_l}, 2'b11);
        chk2("rst_dout", {dout_m, dout_l}, 2'b01);
        chk2("rst_frame", {frame_m, frame_l}, 2'b00);
        chk2("rst_trig", {trig_m, trig_l}, 2'b00);
        chk2("rst_done", {done_m, done_l}, 2'b00);
        reset_ni = 1'b1;
        shift_en = 1'b1;
        tick();
        chk2("rst_rel_frame", {frame_m, frame_l}, 2'b00);

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i]);
        end

        // Two words back to back: one continuous 16-bit frame.
        exp16_m = 16'hF00F;
        exp16_l = 16'h0FF0;
        pend.push_back(8'hF0);
        pend.push_back(8'h0F);
        drive();
        shift_en = 1'b1;
        tick();
        chk2("b2b_ready_held", {rdy_m, rdy_l}, 2'b00);
        tick();
        for (int k = 0; k < 16; k++) begin
            t = (k == 0 || k == 8);
            r = (k == 0 || k >= 8);
            chk2("b2b_dout", {dout_m, dout_l}, {exp16_m[15 - k], exp16_l[15 - k]});
            chk2("b2b_frame", {frame_m, frame_l}, 2'b11);
            chk2("b2b_trig", {trig_m, trig_l}, {t, t});
            chk2("b2b_ready", {rdy_m, rdy_l}, {r, r});
            chk2("b2b_done_early", {done_m, done_l}, 2'b00);
            tick();
        end
        chk2("b2b_done", {done_m, done_l}, 2'b11);
        chk2("b2b_end_frame", {frame_m, frame_l}, 2'b00);
        tick();
        chk2("b2b_done_once", {done_m, done_l}, 2'b00);

        // Word accepted in the cycle the last bit completes: one idle cycle.
        pend.push_back(8'h3C);
        drive();
        tick();
        tick();
        for (int k = 0; k < 8; k++) begin
            if (k == 7) begin
                pend.push_back(8'h5A);
                drive();
            end
            chk2("gap_frame", {frame_m, frame_l}, 2'b11);
            tick();
        end
        chk2("gap_idle_frame", {frame_m, frame_l}, 2'b00);
        chk2("gap_idle_dout", {dout_m, dout_l}, 2'b01);
        chk2("gap_idle_done", {done_m, done_l}, 2'b11);
        chk2("gap_idle_ready", {rdy_m, rdy_l}, 2'b00);
        tick();
        chk2("gap_reload_frame", {frame_m, frame_l}, 2'b11);
        chk2("gap_reload_trig", {trig_m, trig_l}, 2'b11);
        chk2("gap_reload_dout", {dout_m, dout_l}, 2'b00);
        guard = 0;
        while (!done_m && guard < 40) begin
            tick();
            guard++;
        end
        chk2("gap_drain_done", {done_m, done_l}, 2'b11);
        tick();

        // Reset mid-frame with a second word held.
        pend.push_back(8'hFF);
        pend.push_back(8'h55);
        drive();
        tick();
        tick();
        repeat (4) tick();
        chk2("rstmid_held", {rdy_m, rdy_l}, 2'b00);
        chk2("rstmid_dout", {dout_m, dout_l}, 2'b11);
        reset_ni = 1'b0;
        tick();
        chk2("rstmid_dout_idle", {dout_m, dout_l}, 2'b01);
        chk2("rstmid_ready", {rdy_m, rdy_l}, 2'b11);
        chk2("rstmid_frame", {frame_m, frame_l}, 2'b00);
        chk2("rstmid_done", {done_m, done_l}, 2'b00);
        chk2("rstmid_trig", {trig_m, trig_l}, 2'b00);
        sb_m.delete();
        sb_l.delete();
        pend.delete();
        drive();
        reset_ni = 1'b1;
        for (int c = 0; c < 12; c++) begin
            chk2("rstmid_no_frame", {frame_m, frame_l}, 2'b00);
            chk2("rstmid_no_done", {done_m, done_l}, 2'b00);
            tick();
        end

        // Random loopback through the receiver model.
        base = rx_words;
        for (int i = 0; i < 100; i++) begin
            pend.push_back(8'($urandom));
        end
        drive();
        guard = 0;
        while (!(pend.size() == 0 && sb_m.size() == 0 && !frame_m) && guard < 6000) begin
            shift_en = ($urandom_range(0, 3) != 0);
            tick();
            guard++;
        end
        chkint("lb_words", rx_words - base, 100);
        chkint("lb_sb_left", sb_m.size() + sb_l.size(), 0);
        shift_en = 1'b0;
        repeat (3) tick();
        chk2("lb_end_frame", {frame_m, frame_l}, 2'b00);
        chk2("lb_end_ready", {rdy_m, rdy_l}, 2'b11);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
